// File: rtl/wishbone_shared_bus_pkg.sv
// Shared types for the Wishbone shared-bus transfer controller.
// Transfer states, fan-out counts and grant helpers.
package wishbone_shared_bus_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int NUM_SLAVES  = 4;
  localparam int TW          = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  function automatic logic is_onehot4(
    input logic [NUM_MASTERS-1:0] v
  );
    logic [NUM_MASTERS-1:0] vm1;
    vm1 = v - NUM_MASTERS'(1);
    return (v != '0) && ((v & vm1) == '0);
  endfunction

endpackage

// File: rtl/wishbone_shared_bus_addr_decoder.sv
// Address decoder: one-hot slave select, lowest index wins.
// Flags addresses that hit no slave window.
module wb_addr_decoder
  import wishbone_shared_bus_pkg::*;
#(
  parameter int AW = 32,
  parameter logic [AW-1:0] S0_BASE = AW'(32'h0000_0000),
  parameter logic [AW-1:0] S1_BASE = AW'(32'h1000_0000),
  parameter logic [AW-1:0] S2_BASE = AW'(32'h2000_0000),
  parameter logic [AW-1:0] S3_BASE = AW'(32'h3000_0000),
  parameter logic [AW-1:0] S0_MASK = AW'(32'hF000_0000),
  parameter logic [AW-1:0] S1_MASK = AW'(32'hF000_0000),
  parameter logic [AW-1:0] S2_MASK = AW'(32'hF000_0000),
  parameter logic [AW-1:0] S3_MASK = AW'(32'hF000_0000)
) (
  input  logic [AW-1:0]         adr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [1:0]            idx,
  output logic                  miss
);

  localparam logic [AW-1:0] BASE [NUM_SLAVES] =
    '{S0_BASE, S1_BASE, S2_BASE, S3_BASE};
  localparam logic [AW-1:0] MASK [NUM_SLAVES] =
    '{S0_MASK, S1_MASK, S2_MASK, S3_MASK};

  logic [NUM_SLAVES-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      hit[i] = (adr & MASK[i]) == BASE[i];
  end

  // Walk downward so the lowest matching index is written last.
  always_comb begin
    sel  = '0;
    idx  = '0;
    miss = (hit == '0);
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
        idx    = 2'(i);
      end
    end
  end

endmodule

// File: rtl/wishbone_shared_bus.sv
// Shared Wishbone bus behind a 4-master arbiter: mux, decode,
// response routing, no-response watchdog and unmapped error.
module wishbone_shared_bus
  import wishbone_shared_bus_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [AW-1:0] S0_BASE = AW'(32'h0000_0000),
  parameter logic [AW-1:0] S1_BASE = AW'(32'h1000_0000),
  parameter logic [AW-1:0] S2_BASE = AW'(32'h2000_0000),
  parameter logic [AW-1:0] S3_BASE = AW'(32'h3000_0000),
  parameter logic [AW-1:0] S0_MASK = AW'(32'hF000_0000),
  parameter logic [AW-1:0] S1_MASK = AW'(32'hF000_0000),
  parameter logic [AW-1:0] S2_MASK = AW'(32'hF000_0000),
  parameter logic [AW-1:0] S3_MASK = AW'(32'hF000_0000),
  parameter int TIMEOUT = 255
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_MASTERS-1:0]     GNT_mux,
  input  logic                       CYC,
  input  logic [NUM_MASTERS-1:0]     M_STB_I,
  input  logic [NUM_MASTERS-1:0]     M_WE_I,
  input  logic [NUM_MASTERS*AW-1:0]  M_ADR_I,
  input  logic [NUM_MASTERS*DW-1:0]  M_DAT_I,
  input  logic [NUM_MASTERS*DW/8-1:0] M_SEL_I,
  output logic [DW-1:0]              M_DAT_O,
  output logic [NUM_MASTERS-1:0]     M_ACK_O,
  output logic [NUM_MASTERS-1:0]     M_ERR_O,
  output logic [NUM_SLAVES-1:0]      S_CYC_O,
  output logic [NUM_SLAVES-1:0]      S_STB_O,
  output logic                       S_WE_O,
  output logic [AW-1:0]              S_ADR_O,
  output logic [DW-1:0]              S_DAT_O,
  output logic [DW/8-1:0]            S_SEL_O,
  input  logic [NUM_SLAVES*DW-1:0]   S_DAT_I,
  input  logic [NUM_SLAVES-1:0]      S_ACK_I
);

  localparam int SW = DW / 8;

  bus_state_e state, state_n;

  logic [TW-1:0] cnt, cnt_n;
  logic [1:0]    g_q, s_q;

  logic          gnt_ok;
  logic [1:0]    g_sel;
  logic          m_stb;
  logic          m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat;
  logic [SW-1:0] m_sel;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic [1:0]            dec_idx;
  logic                  dec_miss;

  logic          s_ack;
  logic [DW-1:0] s_rdata;
  logic          cnt_hit;

  logic req_go, req_miss;
  logic done_ack, done_err, drop;

  // Zero or multi-hot grant is treated as no request at all.
  always_comb begin
    gnt_ok = is_onehot4(GNT_mux);
    g_sel  = '0;
    if (gnt_ok) begin
      unique case (1'b1)
        GNT_mux[0]: g_sel = 2'd0;
        GNT_mux[1]: g_sel = 2'd1;
        GNT_mux[2]: g_sel = 2'd2;
        GNT_mux[3]: g_sel = 2'd3;
      endcase
    end
  end

  assign m_stb = M_STB_I[g_sel];
  assign m_we  = M_WE_I[g_sel];
  assign m_adr = M_ADR_I[g_sel*AW +: AW];
  assign m_dat = M_DAT_I[g_sel*DW +: DW];
  assign m_sel = M_SEL_I[g_sel*SW +: SW];

  wb_addr_decoder #(
    .AW      (AW),
    .S0_BASE (S0_BASE),
    .S1_BASE (S1_BASE),
    .S2_BASE (S2_BASE),
    .S3_BASE (S3_BASE),
    .S0_MASK (S0_MASK),
    .S1_MASK (S1_MASK),
    .S2_MASK (S2_MASK),
    .S3_MASK (S3_MASK)
  ) u_dec (
    .adr  (m_adr),
    .sel  (dec_sel),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  assign s_ack   = S_ACK_I[s_q];
  assign s_rdata = S_DAT_I[s_q*DW +: DW];
  assign cnt_hit = ({1'b0, cnt} + 17'd1) == 17'(TIMEOUT);

  always_comb begin
    state_n  = state;
    cnt_n    = '0;
    req_go   = 1'b0;
    req_miss = 1'b0;
    done_ack = 1'b0;
    done_err = 1'b0;
    drop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (CYC && gnt_ok && m_stb) begin
          if (dec_miss) begin
            req_miss = 1'b1;
            state_n  = ST_RESP;
          end else begin
            req_go  = 1'b1;
            state_n = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        // ACK beats both abort and the watchdog.
        if (s_ack) begin
          done_ack = 1'b1;
          state_n  = ST_RESP;
        end else if (!CYC) begin
          drop    = 1'b1;
          state_n = ST_IDLE;
        end else if (cnt_hit) begin
          done_err = 1'b1;
          state_n  = ST_RESP;
        end else begin
          cnt_n = cnt + TW'(1);
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      g_q     <= '0;
      s_q     <= '0;
      S_CYC_O <= '0;
      S_STB_O <= '0;
      S_WE_O  <= 1'b0;
      S_ADR_O <= '0;
      S_DAT_O <= '0;
      S_SEL_O <= '0;
      M_DAT_O <= '0;
      M_ACK_O <= '0;
      M_ERR_O <= '0;
    end else begin
      M_ACK_O <= '0;
      M_ERR_O <= '0;
      if (req_go || req_miss) begin
        g_q     <= g_sel;
        s_q     <= dec_idx;
        S_WE_O  <= m_we;
        S_ADR_O <= m_adr;
        S_DAT_O <= m_dat;
        S_SEL_O <= m_sel;
      end
      if (req_go) begin
        S_CYC_O <= dec_sel;
        S_STB_O <= dec_sel;
      end
      if (req_miss)
        M_ERR_O <= NUM_MASTERS'(1) << g_sel;
      if (done_ack || done_err || drop) begin
        S_CYC_O <= '0;
        S_STB_O <= '0;
      end
      if (done_ack) begin
        M_ACK_O <= NUM_MASTERS'(1) << g_q;
        if (!S_WE_O)
          M_DAT_O <= s_rdata;
      end
      if (done_err)
        M_ERR_O <= NUM_MASTERS'(1) << g_q;
    end
  end

endmodule

// File: tb/tb_wishbone_shared_bus.sv
// Directed plus randomized bench for wishbone_shared_bus.
// Expected responses come from a top-nibble address map model.
module tb_wishbone_shared_bus;

  localparam int TO = 4;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [3:0]   GNT_mux;
  logic         CYC;
  logic [3:0]   M_STB_I;
  logic [3:0]   M_WE_I;
  logic [127:0] M_ADR_I;
  logic [127:0] M_DAT_I;
  logic [15:0]  M_SEL_I;
  logic [31:0]  M_DAT_O;
  logic [3:0]   M_ACK_O;
  logic [3:0]   M_ERR_O;
  logic [3:0]   S_CYC_O;
  logic [3:0]   S_STB_O;
  logic         S_WE_O;
  logic [31:0]  S_ADR_O;
  logic [31:0]  S_DAT_O;
  logic [3:0]   S_SEL_O;
  logic [127:0] S_DAT_I;
  logic [3:0]   S_ACK_I;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_mdat = '0;

  always #5 CLK = ~CLK;

  // S2 and S3 overlap on 0x2xxx_xxxx; S2 must win there.
  wishbone_shared_bus #(
    .AW      (32),
    .DW      (32),
    .S2_BASE (32'h2000_0000),
    .S2_MASK (32'hF000_0000),
    .S3_BASE (32'h2000_0000),
    .S3_MASK (32'hE000_0000),
    .TIMEOUT (TO)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .GNT_mux (GNT_mux),
    .CYC     (CYC),
    .M_STB_I (M_STB_I),
    .M_WE_I  (M_WE_I),
    .M_ADR_I (M_ADR_I),
    .M_DAT_I (M_DAT_I),
    .M_SEL_I (M_SEL_I),
    .M_DAT_O (M_DAT_O),
    .M_ACK_O (M_ACK_O),
    .M_ERR_O (M_ERR_O),
    .S_CYC_O (S_CYC_O),
    .S_STB_O (S_STB_O),
    .S_WE_O  (S_WE_O),
    .S_ADR_O (S_ADR_O),
    .S_DAT_O (S_DAT_O),
    .S_SEL_O (S_SEL_O),
    .S_DAT_I (S_DAT_I),
    .S_ACK_I (S_ACK_I)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Address map: top nibble 0..3 selects that slave, rest unmapped.
  function automatic int ref_slave(input logic [31:0] adr);
    int n;
    n = int'(adr[31:28]);
    return (n < 4) ? n : -1;
  endfunction

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_stb"}, 32'(S_STB_O), 32'h0);
    chk({tag, "_cyc"}, 32'(S_CYC_O), 32'h0);
    chk({tag, "_ack"}, 32'(M_ACK_O), 32'h0);
    chk({tag, "_err"}, 32'(M_ERR_O), 32'h0);
  endtask

  task automatic present(input int m, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    M_ADR_I = {$urandom, $urandom, $urandom, $urandom};
    M_DAT_I = {$urandom, $urandom, $urandom, $urandom};
    M_SEL_I = 16'($urandom);
    M_WE_I  = 4'($urandom);
    M_STB_I = 4'($urandom) | (4'b0001 << m);
    M_ADR_I[m*32 +: 32] = adr;
    M_DAT_I[m*32 +: 32] = dat;
    M_SEL_I[m*4 +: 4]   = sel;
    M_WE_I[m]           = we;
    GNT_mux = 4'b0001 << m;
    CYC     = 1'b1;
  endtask

  // Called in an IDLE cycle; returns in the following IDLE cycle.
  // w = ACTIVE cycles before the slave ACKs (large = never).
  task automatic do_xfer(input int m, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int w,
                         input logic [31:0] rdata);
    int s;
    int n;
    logic [3:0] mbit;
    logic [3:0] sbit;
    s    = ref_slave(adr);
    mbit = 4'b0001 << m;
    present(m, we, adr, dat, sel);
    step();
    if (s < 0) begin
      chk("unm_err", 32'(M_ERR_O), 32'(mbit));
      chk("unm_stb", 32'(S_STB_O), 32'h0);
      chk("unm_ack", 32'(M_ACK_O), 32'h0);
    end else begin
      sbit = 4'b0001 << s;
      n = (w + 1 < TO) ? w + 1 : TO;
      for (int i = 0; i < n; i++) begin
        chk("act_stb", 32'(S_STB_O), 32'(sbit));
        chk("act_cyc", 32'(S_CYC_O), 32'(sbit));
        chk("act_adr", S_ADR_O, adr);
        chk("act_dat", S_DAT_O, dat);
        chk("act_sel", 32'(S_SEL_O), 32'(sel));
        chk("act_we", 32'(S_WE_O), 32'(we));
        chk("act_ack", 32'(M_ACK_O), 32'h0);
        chk("act_err", 32'(M_ERR_O), 32'h0);
        M_ADR_I[m*32 +: 32] = $urandom;
        S_DAT_I = {$urandom, $urandom, $urandom, $urandom};
        S_DAT_I[s*32 +: 32] = rdata;
        S_ACK_I = (i == w) ? sbit : (4'($urandom) & ~sbit);
        step();
      end
      S_ACK_I = '0;
      if (w < TO) begin
        if (!we)
          exp_mdat = rdata;
        chk("rsp_ack", 32'(M_ACK_O), 32'(mbit));
        chk("rsp_err", 32'(M_ERR_O), 32'h0);
      end else begin
        chk("to_err", 32'(M_ERR_O), 32'(mbit));
        chk("to_ack", 32'(M_ACK_O), 32'h0);
      end
      chk("rsp_stb", 32'(S_STB_O), 32'h0);
      chk("rsp_cyc", 32'(S_CYC_O), 32'h0);
      chk("rsp_mdat", M_DAT_O, exp_mdat);
    end
    step();
    chk_idle_outs("post");
    chk("post_mdat", M_DAT_O, exp_mdat);
    CYC     = 1'b0;
    M_STB_I = '0;
  endtask

  initial begin
    RST_N   = 1'b0;
    GNT_mux = '0;
    CYC     = 1'b0;
    M_STB_I = '0;
    M_WE_I  = '0;
    M_ADR_I = '0;
    M_DAT_I = '0;
    M_SEL_I = '0;
    S_DAT_I = '0;
    S_ACK_I = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_idle_outs("rst");
    chk("rst_mdat", M_DAT_O, 32'h0);
    chk("rst_adr", S_ADR_O, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();

    // Master 1 write, ACK on third ACTIVE cycle.
    do_xfer(1, 1'b1, 32'h1000_0010, 32'hCAFE_0001, 4'hF, 2,
            32'h1111_1111);
    // Master 0 zero-wait read.
    do_xfer(0, 1'b0, 32'h0000_0004, 32'h0, 4'hF, 0, 32'hDEAD_BEEF);
    // Unmapped read.
    do_xfer(2, 1'b0, 32'hF000_0000, 32'h0, 4'hF, 0, 32'h0);
    // Watchdog fires, then ACK on the watchdog cycle wins.
    do_xfer(3, 1'b0, 32'h3000_0100, 32'h0, 4'h3, 99, 32'h5555_AAAA);
    do_xfer(3, 1'b0, 32'h3000_0100, 32'h0, 4'h3, TO - 1,
            32'h1234_5678);
    // Overlap: 0x2 goes to S2 even though S3 also matches.
    do_xfer(2, 1'b0, 32'h2000_0040, 32'h0, 4'h1, 1, 32'h0BAD_F00D);

    // Master abort mid-ACTIVE.
    present(0, 1'b0, 32'h1000_0000, 32'h0, 4'hF);
    step();
    chk("abt_stb", 32'(S_STB_O), 32'h2);
    step();
    CYC     = 1'b0;
    M_STB_I = '0;
    step();
    chk_idle_outs("abt");
    step();
    chk_idle_outs("abt_idle");
    // Counter must restart from zero after the abort.
    do_xfer(0, 1'b0, 32'h1000_0008, 32'h0, 4'hF, TO - 1,
            32'hA5A5_5A5A);

    // Bad grants issue nothing.
    present(1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
    M_STB_I = 4'hF;
    GNT_mux = 4'b0000;
    step();
    chk_idle_outs("gnt0");
    GNT_mux = 4'b0110;
    step();
    chk_idle_outs("gnt_multi");
    CYC     = 1'b0;
    M_STB_I = '0;
    GNT_mux = '0;
    step();

    // Back-to-back zero-wait transfers every 3 cycles.
    for (int k = 0; k < 4; k++)
      do_xfer(k, 1'b0, {4'(k), 28'(k * 16)}, 32'h0, 4'hF, 0,
              32'hB000_0000 + 32'(k));
    step();
    chk_idle_outs("b2b_end");

    // Randomized transfers.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      int w;
      a = $urandom;
      a[31:28] = ($urandom_range(0, 7) == 7) ? 4'hF
                                             : 4'($urandom_range(0, 5));
      w = ($urandom_range(0, 5) == 5) ? 99 : $urandom_range(0, 3);
      do_xfer($urandom_range(0, 3), 1'($urandom), a, $urandom,
              4'($urandom), w, $urandom);
      if ($urandom_range(0, 2) == 0)
        step();
    end

    // Asynchronous reset in the middle of ACTIVE.
    present(2, 1'b0, 32'h1000_0020, 32'h77, 4'hF);
    step();
    chk("rsta_stb", 32'(S_STB_O), 32'h2);
    RST_N = 1'b0;
    #1;
    chk_idle_outs("rsta");
    chk("rsta_mdat", M_DAT_O, 32'h0);
    chk("rsta_adr", S_ADR_O, 32'h0);
    exp_mdat = '0;
    CYC     = 1'b0;
    M_STB_I = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    do_xfer(1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1, 32'hFEED_FACE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
